// File: rtl/huffman_sched.sv
// Frame scheduler for the shared huffman engine: round-robin grant between two
// image sources, engine clear, pixel streaming and completion/timeout reporting.
module huffman_sched #(
    parameter int NPIX    = 100,
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 255,
    parameter int CLR_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_q0,
    input  logic [7:0]        img_q1,
    output logic              core_rst,
    output logic              gray_valid,
    output logic [7:0]        gray_data,
    input  logic              CNT_valid,
    input  logic              code_valid,
    output logic [1:0]        done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR       = 3'd1,
        STREAM    = 3'd2,
        DRAIN     = 3'd3,
        WAIT_CNT  = 3'd4,
        WAIT_CODE = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [7:0]        CLR_LAST  = 8'(CLR_CYC - 1);
    localparam logic [7:0]        TMO_LAST  = 8'(TIMEOUT - 1);

    state_t     state_r;
    logic       rr_r;
    logic [7:0] clr_cnt_r;
    logic [7:0] tmo_cnt_r;

    // Frame sequencer: all control outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            rr_r      <= 1'b1;
            clr_cnt_r <= 8'd0;
            tmo_cnt_r <= 8'd0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            img_rd    <= 1'b0;
            img_addr  <= '0;
            core_rst  <= 1'b0;
            done      <= 2'b00;
            err       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 2'b00;
                    err  <= 1'b0;
                    if (req != 2'b00) begin
                        // Pointer only moves on a tie; a lone requester leaves it alone.
                        if (req == 2'b11) begin
                            if (rr_r) begin
                                gnt  <= 2'b01;
                                rr_r <= 1'b0;
                            end else begin
                                gnt  <= 2'b10;
                                rr_r <= 1'b1;
                            end
                        end else begin
                            gnt <= req;
                        end
                        busy      <= 1'b1;
                        core_rst  <= 1'b1;
                        clr_cnt_r <= 8'd0;
                        state_r   <= CLR;
                    end
                end
                CLR: begin
                    if (clr_cnt_r == CLR_LAST) begin
                        core_rst <= 1'b0;
                        img_rd   <= 1'b1;
                        img_addr <= '0;
                        state_r  <= STREAM;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + 8'd1;
                    end
                end
                STREAM: begin
                    if (img_addr == LAST_ADDR) begin
                        img_rd  <= 1'b0;
                        state_r <= DRAIN;
                    end else begin
                        img_addr <= img_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    tmo_cnt_r <= 8'd0;
                    state_r   <= WAIT_CNT;
                end
                WAIT_CNT: begin
                    // An arriving input beats a simultaneous timeout.
                    if (CNT_valid) begin
                        tmo_cnt_r <= 8'd0;
                        state_r   <= WAIT_CODE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        done    <= gnt;
                        err     <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                WAIT_CODE: begin
                    if (code_valid) begin
                        done    <= gnt;
                        err     <= 1'b0;
                        state_r <= DONE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        done    <= gnt;
                        err     <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    done     <= 2'b00;
                    err      <= 1'b0;
                    gnt      <= 2'b00;
                    busy     <= 1'b0;
                    img_addr <= '0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    gnt      <= 2'b00;
                    busy     <= 1'b0;
                    img_rd   <= 1'b0;
                    core_rst <= 1'b0;
                    done     <= 2'b00;
                    err      <= 1'b0;
                end
            endcase
        end
    end

    // Pixel valid tracks the one-cycle memory read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gray_valid <= 1'b0;
        end else begin
            gray_valid <= img_rd;
        end
    end

    // Pixel mux from the granted source's memory.
    always_comb begin
        gray_data = 8'd0;
        if (gnt[0]) begin
            gray_data = img_q0;
        end else if (gnt[1]) begin
            gray_data = img_q1;
        end else begin
            gray_data = 8'd0;
        end
    end

endmodule
